matrix_rx_monitor: RTL

- Receive-side model of the LED-driver serial interface (sdi/dclk/le/gclk) driven by the matrix scan controller.
- Oversamples the pins on the system clock, shifts 16-bit words and decodes latch commands by the number of DCLK rising edges seen while LE is high.
- Presents the decoded data words, config registers and frame events.
- Used in-FPGA as a loopback checker and as the bench-side responder for controller verification.

---
 rtl/matrix_rx_monitor_if.sv | 45 ++++
 rtl/matrix_rx_monitor.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/matrix_rx_monitor_if.sv
// Pin-level LED-driver serial bus (sdi/dclk/le/gclk) plus the monitor's decoded outputs.
// Defining MATRIX_RX_GCLK_MON_EN adds the gclk_count/gclk_per_frame outputs.
interface matrix_rx_monitor_if #(
  parameter int WORD_INDEX_WIDTH = 12
);
  logic                        sdi;
  logic                        dclk;
  logic                        le;
  logic                        gclk;
  logic [15:0]                 data_word;
  logic                        data_valid;
  logic [WORD_INDEX_WIDTH-1:0] word_index;
  logic                        vsync;
  logic [15:0]                 cfg1;
  logic [15:0]                 cfg2;
  logic [1:0]                  cfg_valid;
  logic                        outputs_en;
  logic                        cmd_error;
`ifdef MATRIX_RX_GCLK_MON_EN
  logic [15:0]                 gclk_count;
  logic [15:0]                 gclk_per_frame;

  modport master (
    output sdi, dclk, le, gclk,
    input  data_word, data_valid, word_index, vsync, cfg1, cfg2, cfg_valid,
           outputs_en, cmd_error, gclk_count, gclk_per_frame
  );
  modport slave (
    input  sdi, dclk, le, gclk,
    output data_word, data_valid, word_index, vsync, cfg1, cfg2, cfg_valid,
           outputs_en, cmd_error, gclk_count, gclk_per_frame
  );
`else
  modport master (
    output sdi, dclk, le, gclk,
    input  data_word, data_valid, word_index, vsync, cfg1, cfg2, cfg_valid,
           outputs_en, cmd_error
  );
  modport slave (
    input  sdi, dclk, le, gclk,
    output data_word, data_valid, word_index, vsync, cfg1, cfg2, cfg_valid,
           outputs_en, cmd_error
  );
`endif
endinterface

// File: rtl/matrix_rx_monitor.sv
// Oversampling receiver for the LED-driver serial bus; decodes LE commands 1 clk after the synchronized LE fall.
// No backpressure (pins are free-running); MATRIX_RX_GCLK_MON_EN adds per-frame GCLK counting.
module matrix_rx_monitor #(
  parameter int SYNC_STAGES      = 2,
  parameter int WORD_INDEX_WIDTH = 12,
  parameter int LE_CNT_WIDTH     = 5
) (
  input  logic               clk,
  input  logic               rst,
  matrix_rx_monitor_if.slave bus
);

  localparam logic [LE_CNT_WIDTH-1:0] CMD_DATA   = LE_CNT_WIDTH'(1);
  localparam logic [LE_CNT_WIDTH-1:0] CMD_VSYNC  = LE_CNT_WIDTH'(3);
  localparam logic [LE_CNT_WIDTH-1:0] CMD_CFG1   = LE_CNT_WIDTH'(4);
  localparam logic [LE_CNT_WIDTH-1:0] CMD_CFG2   = LE_CNT_WIDTH'(6);
  localparam logic [LE_CNT_WIDTH-1:0] CMD_OUT_EN = LE_CNT_WIDTH'(12);
  localparam logic [LE_CNT_WIDTH-1:0] CMD_PREACT = LE_CNT_WIDTH'(14);

  logic [SYNC_STAGES-1:0]  sdi_q;
  logic [SYNC_STAGES-1:0]  dclk_q;
  logic [SYNC_STAGES-1:0]  le_q;
  logic                    dclk_h;
  logic                    le_h;
  logic [15:0]             sr;
  logic [LE_CNT_WIDTH-1:0] le_cnt;
  logic                    preact_armed;

  logic sdi_s;
  logic dclk_s;
  logic le_s;
  logic dclk_rise;
  logic le_fall;

  assign sdi_s     = sdi_q[SYNC_STAGES-1];
  assign dclk_s    = dclk_q[SYNC_STAGES-1];
  assign le_s      = le_q[SYNC_STAGES-1];
  assign dclk_rise = dclk_s & ~dclk_h;
  assign le_fall   = ~le_s & le_h;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sdi_q  <= '0;
      dclk_q <= '0;
      le_q   <= '0;
      dclk_h <= 1'b0;
      le_h   <= 1'b0;
    end else begin
      sdi_q  <= {sdi_q[SYNC_STAGES-2:0], bus.sdi};
      dclk_q <= {dclk_q[SYNC_STAGES-2:0], bus.dclk};
      le_q   <= {le_q[SYNC_STAGES-2:0], bus.le};
      dclk_h <= dclk_s;
      le_h   <= le_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr             <= '0;
      le_cnt         <= '0;
      preact_armed   <= 1'b0;
      bus.data_word  <= '0;
      bus.data_valid <= 1'b0;
      bus.word_index <= '0;
      bus.vsync      <= 1'b0;
      bus.cfg1       <= '0;
      bus.cfg2       <= '0;
      bus.cfg_valid  <= '0;
      bus.outputs_en <= 1'b0;
      bus.cmd_error  <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.vsync      <= 1'b0;
      bus.cfg_valid  <= '0;
      bus.cmd_error  <= 1'b0;

      // The index moves on the cycle after the pulse so consumers see the word's own index.
      if (bus.data_valid) begin
        bus.word_index <= bus.word_index + WORD_INDEX_WIDTH'(1);
      end

      if (dclk_rise) begin
        sr <= {sr[14:0], sdi_s};
      end

      if (le_fall) begin
        le_cnt <= '0;
        if (le_cnt != CMD_PREACT && le_cnt != '0) begin
          preact_armed <= 1'b0;
        end
        case (le_cnt)
          '0: ;
          CMD_DATA: begin
            bus.data_word  <= sr;
            bus.data_valid <= 1'b1;
          end
          CMD_VSYNC: begin
            bus.vsync      <= 1'b1;
            bus.word_index <= '0;
          end
          CMD_CFG1: begin
            if (preact_armed) begin
              bus.cfg1      <= sr;
              bus.cfg_valid <= 2'b01;
            end else begin
              bus.cmd_error <= 1'b1;
            end
          end
          CMD_CFG2: begin
            if (preact_armed) begin
              bus.cfg2      <= sr;
              bus.cfg_valid <= 2'b10;
            end else begin
              bus.cmd_error <= 1'b1;
            end
          end
          CMD_OUT_EN: bus.outputs_en <= 1'b1;
          CMD_PREACT: preact_armed   <= 1'b1;
          default:    bus.cmd_error  <= 1'b1;
        endcase
      end else if (dclk_rise && le_s && le_cnt != '1) begin
        le_cnt <= le_cnt + LE_CNT_WIDTH'(1);
      end
    end
  end

`ifdef MATRIX_RX_GCLK_MON_EN
  logic [SYNC_STAGES-1:0] gclk_q;
  logic                   gclk_h;
  logic                   gclk_rise;
  logic                   vsync_dec;

  assign gclk_rise = gclk_q[SYNC_STAGES-1] & ~gclk_h;
  assign vsync_dec = le_fall && (le_cnt == CMD_VSYNC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gclk_q             <= '0;
      gclk_h             <= 1'b0;
      bus.gclk_count     <= '0;
      bus.gclk_per_frame <= '0;
    end else begin
      gclk_q <= {gclk_q[SYNC_STAGES-2:0], bus.gclk};
      gclk_h <= gclk_q[SYNC_STAGES-1];
      // Frame boundary wins over a coincident gclk edge.
      if (vsync_dec) begin
        bus.gclk_per_frame <= bus.gclk_count;
        bus.gclk_count     <= '0;
      end else if (gclk_rise && bus.gclk_count != 16'hFFFF) begin
        bus.gclk_count <= bus.gclk_count + 16'd1;
      end
    end
  end
`else
  logic unused_gclk;
  assign unused_gclk = bus.gclk;
`endif

endmodule
